ship_sprite_renderer: RTL

//   Consumes the 8-bit ship x position from the movement handler and paints the player

---
 rtl/ship_sprite_renderer_if.sv | 23 ++
 rtl/ship_sprite_renderer.sv | 96 +++++++++
 2 files changed

// File: rtl/ship_sprite_renderer_if.sv
// Movement handler / plotter side bundle for the ship sprite renderer.
// master = movement handler + plot consumer, slave = renderer.
interface ship_sprite_renderer_if;
    logic [7:0] x_val;
    logic       enable;
    logic       force_redraw;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output x_val, enable, force_redraw,
        input  plot_x, plot_y, plot_colour, plot, busy, done
    );

    modport slave (
        input  x_val, enable, force_redraw,
        output plot_x, plot_y, plot_colour, plot, busy, done
    );
endinterface

// File: rtl/ship_sprite_renderer.sv
// Ship sprite renderer: on an x change (or forced redraw) erases the old 8x8
// sprite in black, then draws the new one, one pixel per clock.
module ship_sprite_renderer #(
    parameter int          SPRITE_W = 8,
    parameter int          SPRITE_H = 8,
    parameter logic [6:0]  Y_TOP    = 7'd112,
    parameter logic [7:0]  X_MAX    = 8'd120,
    parameter logic [2:0]  COLOUR   = 3'b111,
    parameter logic [63:0] SPRITE   = 64'h183C7EDBFF245A81
) (
    input  logic                  clock,
    input  logic                  reset,
    ship_sprite_renderer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ERASE = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Last scan index of the 8x8 raster.
    localparam logic [5:0] LAST = 6'(SPRITE_W * SPRITE_H - 1);

    logic [1:0] state;
    logic [5:0] idx;
    logic [7:0] new_x;
    logic [7:0] drawn_x;
    logic       drawn_valid;
    logic       force_pend;
    logic [7:0] tgt;
    logic [7:0] col_off;
    logic [6:0] row_off;

    assign tgt     = (bus.x_val > X_MAX) ? X_MAX : bus.x_val;
    assign col_off = {5'd0, idx[2:0]};
    assign row_off = {4'd0, idx[5:3]};

    // Frame sequencer plus registered plotter outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= 6'd0;
            new_x           <= 8'd0;
            drawn_x         <= 8'd0;
            drawn_valid     <= 1'b0;
            force_pend      <= 1'b0;
            bus.plot_x      <= 8'd0;
            bus.plot_y      <= 7'd0;
            bus.plot_colour <= 3'd0;
            bus.plot        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.plot <= 1'b0;
            bus.done <= 1'b0;
            if (bus.force_redraw)
                force_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.enable && (!drawn_valid || tgt != drawn_x || force_pend)) begin
                        new_x      <= tgt;
                        idx        <= 6'd0;
                        force_pend <= 1'b0;
                        bus.busy   <= 1'b1;
                        state      <= drawn_valid ? ERASE : DRAW;
                    end
                end
                ERASE: begin
                    bus.plot        <= 1'b1;
                    bus.plot_x      <= drawn_x + col_off;
                    bus.plot_y      <= Y_TOP + row_off;
                    bus.plot_colour <= 3'd0;
                    idx             <= idx + 6'd1;
                    if (idx == LAST)
                        state <= DRAW;
                end
                DRAW: begin
                    // Coordinates advance every cycle; only set bits strobe the plotter.
                    bus.plot        <= SPRITE[6'd63 - idx];
                    bus.plot_x      <= new_x + col_off;
                    bus.plot_y      <= Y_TOP + row_off;
                    bus.plot_colour <= COLOUR;
                    idx             <= idx + 6'd1;
                    if (idx == LAST)
                        state <= DONE;
                end
                default: begin
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    drawn_x     <= new_x;
                    drawn_valid <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
